// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its boot loader.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    localparam int          INSTR_W       = 32;
    localparam int          PC_STEP       = 4;
    localparam int          DEF_MEM_BYTES = 1024;
    localparam logic [31:0] DEF_HALT_INST = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_loader.sv
// Boot loader: accepts program words and presents them on a registered memory write port.
module fetch_loader
    import fetch_pkg::*;
#(
    parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
    parameter int          MEM_BYTES = DEF_MEM_BYTES,
    parameter int          AW        = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               active,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    output logic [AW-1:0]      wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               wr_en,
    output logic               load_ready,
    output logic               load_err
);

    localparam logic [AW-1:0] BASE = LOAD_BASE[AW-1:0];
    localparam logic [AW-1:0] STEP = AW'(PC_STEP);
    localparam logic [AW-1:0] LAST = AW'(MEM_BYTES - PC_STEP);

    logic [AW-1:0] load_ptr;
    logic          accept;

    assign load_ready = active;
    assign accept     = active && load_valid;

    // The write strobe, data and address all come from flops so the memory
    // sees one clean, stable write cycle per accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ptr <= BASE;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr  <= load_ptr;
                wr_data  <= load_data;
                load_ptr <= load_ptr + STEP;
                if (load_ptr == LAST) begin
                    load_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, IF/ID register and control FSM, with the boot loader sharing the memory port.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
    parameter int          MEM_BYTES = DEF_MEM_BYTES,
    parameter logic [31:0] HALT_INST = DEF_HALT_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        run_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_err,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_din,
    output logic        imem_memW,
    input  logic [31:0] imem_dout,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        halted,
    output logic [1:0]  fsm_state
);

    localparam int          AW   = $clog2(MEM_BYTES);
    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [AW-1:0] wr_addr;

    assign halted    = (state == ST_HALT);
    assign fsm_state = state;
    assign imem_addr = {{(32-AW){1'b0}}, (imem_memW ? wr_addr : pc[AW-1:0])};

    fetch_loader #(
        .LOAD_BASE (LOAD_BASE),
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .active     (state == ST_LOAD),
        .load_valid (load_valid),
        .load_data  (load_data),
        .wr_addr    (wr_addr),
        .wr_data    (imem_din),
        .wr_en      (imem_memW),
        .load_ready (load_ready),
        .load_err   (load_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            ifid_inst  <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ifid_valid <= 1'b0;
                    if (load_start) begin
                        state <= ST_LOAD;
                    end else if (run_start) begin
                        state <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    ifid_valid <= 1'b0;
                    if (load_valid && load_last) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc         <= redirect_pc & ~32'd3;
                        ifid_valid <= 1'b0;
                    end else if (!stall && !imem_memW) begin
                        // A trailing loader write owns the address bus, so fetch waits it out.
                        if (imem_dout == HALT_INST) begin
                            state      <= ST_HALT;
                            ifid_valid <= 1'b0;
                        end else begin
                            ifid_inst  <= imem_dout;
                            ifid_pc    <= pc;
                            ifid_valid <= 1'b1;
                            pc         <= pc + STEP;
                        end
                    end
                end
                ST_HALT: begin
                    ifid_valid <= 1'b0;
                    if (run_start) begin
                        state <= ST_RUN;
                        pc    <= pc + STEP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: default instance with a byte memory model, plus a LOAD_BASE=0x3F8 instance.
module tb_inst_fetch;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [31:0] exp_addr;
        logic        exp_err;
    } ld_vec_t;

    logic clk;
    logic rst_n;

    logic        load_start, run_start, load_valid, load_last, stall, redirect_valid;
    logic [31:0] load_data, redirect_pc;
    logic        load_ready, load_err, imem_memW, ifid_valid, halted;
    logic [31:0] imem_addr, imem_din, imem_dout, ifid_inst, ifid_pc;
    logic [1:0]  fsm_state;

    logic        load_start_b, run_start_b, load_valid_b, load_last_b, stall_b, redirect_valid_b;
    logic [31:0] load_data_b, redirect_pc_b, imem_dout_b;
    logic        load_ready_b, load_err_b, imem_memW_b, ifid_valid_b, halted_b;
    logic [31:0] imem_addr_b, imem_din_b, ifid_inst_b, ifid_pc_b;
    logic [1:0]  fsm_state_b;

    bit   [7:0]  mem_a [0:1023];
    logic [9:0]  ra;

    logic [63:0] wq_a[$];
    logic [63:0] wq_b[$];
    logic [63:0] fq[$];
    logic [63:0] e_a, e_b, e_f;

    ld_vec_t tab_a [0:3];
    ld_vec_t tab_b [0:2];

    int checks = 0;
    int errors = 0;

    inst_fetch dut_a (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .run_start(run_start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .load_err(load_err),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_din(imem_din), .imem_memW(imem_memW), .imem_dout(imem_dout),
        .ifid_inst(ifid_inst), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .halted(halted), .fsm_state(fsm_state)
    );

    inst_fetch #(.LOAD_BASE(32'h0000_03F8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start_b), .run_start(run_start_b),
        .load_valid(load_valid_b), .load_data(load_data_b), .load_last(load_last_b),
        .load_ready(load_ready_b), .load_err(load_err_b),
        .stall(stall_b), .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
        .imem_addr(imem_addr_b), .imem_din(imem_din_b), .imem_memW(imem_memW_b), .imem_dout(imem_dout_b),
        .ifid_inst(ifid_inst_b), .ifid_pc(ifid_pc_b), .ifid_valid(ifid_valid_b),
        .halted(halted_b), .fsm_state(fsm_state_b)
    );

    // ---------------- clock / memory model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        ra        = imem_addr[9:0];
        imem_dout = {mem_a[ra + 10'd3], mem_a[ra + 10'd2], mem_a[ra + 10'd1], mem_a[ra]};
    end

    always @(posedge clk) begin
        if (imem_memW) begin
            mem_a[imem_addr[9:0]]         <= imem_din[7:0];
            mem_a[imem_addr[9:0] + 10'd1] <= imem_din[15:8];
            mem_a[imem_addr[9:0] + 10'd2] <= imem_din[23:16];
            mem_a[imem_addr[9:0] + 10'd3] <= imem_din[31:24];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string name);
        if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got capture pc %h with no expected fetch queued", name, ifid_pc);
        end else begin
            e_f = fq.pop_front();
            chk({name, "_valid"}, {31'b0, ifid_valid}, 32'd1);
            chk({name, "_pc"}, ifid_pc, e_f[63:32]);
            chk({name, "_inst"}, ifid_inst, e_f[31:0]);
        end
    endtask

    // ---------------- write-port scoreboards ----------------
    always @(negedge clk) begin
        if (rst_n && imem_memW) begin
            if (wq_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_a_unexpected: got write addr %h data %h expected none", imem_addr, imem_din);
            end else begin
                e_a = wq_a.pop_front();
                chk("wr_a_addr", imem_addr, e_a[63:32]);
                chk("wr_a_data", imem_din, e_a[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && imem_memW_b) begin
            if (wq_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_b_unexpected: got write addr %h data %h expected none", imem_addr_b, imem_din_b);
            end else begin
                e_b = wq_b.pop_front();
                chk("wr_b_addr", imem_addr_b, e_b[63:32]);
                chk("wr_b_data", imem_din_b, e_b[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        tab_a[0] = '{32'h1111_1111, 1'b0, 32'h000, 1'b0};
        tab_a[1] = '{32'h2222_2222, 1'b0, 32'h004, 1'b0};
        tab_a[2] = '{32'h3333_3333, 1'b1, 32'h008, 1'b0};
        tab_a[3] = '{DEF_HALT_INST, 1'b1, 32'h00C, 1'b0};
        tab_b[0] = '{32'hA0A0_0001, 1'b0, 32'h3F8, 1'b0};
        tab_b[1] = '{32'hA0A0_0002, 1'b0, 32'h3FC, 1'b0};
        tab_b[2] = '{32'hA0A0_0003, 1'b1, 32'h000, 1'b1};

        rst_n = 1'b0;
        load_start = 0; run_start = 0; load_valid = 0; load_last = 0; stall = 0;
        redirect_valid = 0; load_data = '0; redirect_pc = '0;
        load_start_b = 0; run_start_b = 0; load_valid_b = 0; load_last_b = 0; stall_b = 0;
        redirect_valid_b = 0; load_data_b = '0; redirect_pc_b = '0; imem_dout_b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_memW", {31'b0, imem_memW}, 32'd0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_inst", ifid_inst, 32'd0);
        chk("rst_pc", ifid_pc, 32'd0);
        chk("rst_err", {31'b0, load_err}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_state", {30'b0, fsm_state}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_ready", {31'b0, load_ready}, 32'd0);
        chk("rst_din", imem_din, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 1: three back-to-back loader words
        load_start = 1; step(); load_start = 0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1; load_data = tab_a[i].data; load_last = tab_a[i].last;
            wq_a.push_back({tab_a[i].exp_addr, tab_a[i].data});
            fq.push_back({tab_a[i].exp_addr, tab_a[i].data});
            @(negedge clk);
            chk("ld_ready", {31'b0, load_ready}, 32'd1);
            chk("ld_err", {31'b0, load_err}, {31'b0, tab_a[i].exp_err});
            step();
        end
        load_valid = 0; load_last = 0;
        @(negedge clk);
        chk("ld_idle_state", {30'b0, fsm_state}, 32'd0);
        chk("ld_idle_memW", {31'b0, imem_memW}, 32'd1);
        step();
        @(negedge clk);
        chk("ld_done_memW", {31'b0, imem_memW}, 32'd0);
        chk("ld_done_err", {31'b0, load_err}, 32'd0);
        for (int i = 0; i < 4; i++) chk("mem_byte", {24'b0, mem_a[i]}, 32'h11);

        // Second load session continues at 0x0C with the halt word
        load_start = 1; step(); load_start = 0;
        load_valid = 1; load_data = tab_a[3].data; load_last = tab_a[3].last;
        wq_a.push_back({tab_a[3].exp_addr, tab_a[3].data});
        @(negedge clk);
        chk("ld2_ready", {31'b0, load_ready}, 32'd1);
        step();
        load_valid = 0; load_last = 0;
        step();
        @(negedge clk);
        chk("mem_halt", {mem_a[15], mem_a[14], mem_a[13], mem_a[12]}, DEF_HALT_INST);

        // Test 2: run from 0
        run_start = 1; step(); run_start = 0;
        @(negedge clk);
        chk("run_state", {30'b0, fsm_state}, 32'd2);
        chk("run_addr0", imem_addr, 32'd0);
        chk("run_valid0", {31'b0, ifid_valid}, 32'd0);
        step(); @(negedge clk); check_fetch("f0");
        step(); @(negedge clk); check_fetch("f1");

        // Test 3: stall two cycles at pc 8
        stall = 1;
        repeat (2) begin
            step();
            @(negedge clk);
            chk("stall_pc", ifid_pc, 32'h4);
            chk("stall_valid", {31'b0, ifid_valid}, 32'd1);
            chk("stall_addr", imem_addr, 32'h8);
        end
        stall = 0;
        step(); @(negedge clk); check_fetch("f2");

        // Test 4: halt word at 0x0C
        step(); @(negedge clk);
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_valid", {31'b0, ifid_valid}, 32'd0);
        chk("halt_addr", imem_addr, 32'hC);
        redirect_valid = 1; redirect_pc = 32'h200;
        step(); redirect_valid = 0;
        @(negedge clk);
        chk("halt_redir_flag", {31'b0, halted}, 32'd1);
        chk("halt_redir_addr", imem_addr, 32'hC);
        run_start = 1; step(); run_start = 0;
        @(negedge clk);
        chk("resume_halted", {31'b0, halted}, 32'd0);
        chk("resume_addr", imem_addr, 32'h10);
        fq.push_back({32'h10, 32'h0});
        step(); @(negedge clk); check_fetch("f_resume");

        // Redirect wins over a simultaneous stall
        redirect_valid = 1; redirect_pc = 32'h0000_0103; stall = 1;
        step(); redirect_valid = 0; stall = 0;
        @(negedge clk);
        chk("redir_valid", {31'b0, ifid_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        fq.push_back({32'h100, 32'h0});
        fq.push_back({32'h104, 32'h0});
        step(); @(negedge clk); check_fetch("f_redir0");
        step(); @(negedge clk); check_fetch("f_redir1");

        // Test 5: loader wrap on the 0x3F8 instance
        load_start_b = 1; step(); load_start_b = 0;
        for (int i = 0; i < 3; i++) begin
            load_valid_b = 1; load_data_b = tab_b[i].data; load_last_b = tab_b[i].last;
            wq_b.push_back({tab_b[i].exp_addr, tab_b[i].data});
            @(negedge clk);
            chk("ldb_ready", {31'b0, load_ready_b}, 32'd1);
            chk("ldb_err", {31'b0, load_err_b}, {31'b0, tab_b[i].exp_err});
            step();
        end
        load_valid_b = 0; load_last_b = 0;
        @(negedge clk);
        chk("ldb_err_set", {31'b0, load_err_b}, 32'd1);
        repeat (3) step();
        @(negedge clk);
        chk("ldb_err_sticky", {31'b0, load_err_b}, 32'd1);
        chk("ldb_state", {30'b0, fsm_state_b}, 32'd0);

        // Test 6: reset during a write cycle
        load_start_b = 1; step(); load_start_b = 0;
        load_valid_b = 1; load_data_b = 32'hDEAD_BEEF; load_last_b = 0;
        wq_b.push_back({32'h004, 32'hDEAD_BEEF});
        step();
        load_valid_b = 0;
        @(negedge clk);
        chk("mid_memW", {31'b0, imem_memW_b}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_memW", {31'b0, imem_memW_b}, 32'd0);
        chk("arst_din", imem_din_b, 32'd0);
        chk("arst_state", {30'b0, fsm_state_b}, 32'd0);
        chk("arst_err", {31'b0, load_err_b}, 32'd0);
        chk("arst_ready", {31'b0, load_ready_b}, 32'd0);
        chk("arst_addr", imem_addr_b, 32'd0);
        chk("arst_b_inst", ifid_inst_b, 32'd0);
        chk("arst_b_pc", ifid_pc_b, 32'd0);
        chk("arst_b_valid", {31'b0, ifid_valid_b}, 32'd0);
        chk("arst_b_halted", {31'b0, halted_b}, 32'd0);
        chk("arst_a_valid", {31'b0, ifid_valid}, 32'd0);
        chk("arst_a_pc", ifid_pc, 32'd0);
        chk("arst_a_inst", ifid_inst, 32'd0);
        chk("arst_a_state", {30'b0, fsm_state}, 32'd0);
        chk("arst_a_addr", imem_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        chk("wq_a_empty", wq_a.size(), 32'd0);
        chk("wq_b_empty", wq_b.size(), 32'd0);
        chk("fq_empty", fq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
